// File: rtl/grf_scan_if.sv
// grf_scan_if: host read/write, scan control and scan result bundle for grf_scan_arbiter.
interface grf_scan_if;
    logic        we;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [4:0]  raddr;
    logic [15:0] rdata;
    logic        rvalid;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] mask;
    logic [5:0]  count;

    modport master (
        output we, waddr, wdata, re, raddr, start,
        input  rdata, rvalid, busy, done, mask, count
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, start,
        output rdata, rvalid, busy, done, mask, count
    );
endinterface

// File: rtl/grf_scan_arbiter.sv
// grf_scan_arbiter: 32x16 register file whose read port is shared by the host and a threshold scanner.
// Define GRF_SCAN_BYPASS_EN to forward same-cycle write data to host and scanner reads.
module grf_scan_arbiter (
    input  logic            clk,
    input  logic            rst_n,
    grf_scan_if.slave       bus_if
);
    localparam logic [15:0] THRESH = 16'h0020;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q;
    logic [15:0] mem_q [32];
    logic [4:0]  ptr_q;
    logic [15:0] rdata_q;
    logic        rvalid_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] mask_q;
    logic [5:0]  count_q;
    logic [15:0] host_val_d;
    logic [15:0] scan_val_d;
    logic        flag_d;

`ifdef GRF_SCAN_BYPASS_EN
    always_comb begin
        host_val_d = (bus_if.we && bus_if.waddr == bus_if.raddr) ? bus_if.wdata : mem_q[bus_if.raddr];
        scan_val_d = (bus_if.we && bus_if.waddr == ptr_q) ? bus_if.wdata : mem_q[ptr_q];
        flag_d     = scan_val_d >= THRESH;
    end
`else
    always_comb begin
        host_val_d = mem_q[bus_if.raddr];
        scan_val_d = mem_q[ptr_q];
        flag_d     = scan_val_d >= THRESH;
    end
`endif

    // The host read request doubles as the scanner's stall: re=1 denies the scanner the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= '0;
            state_q  <= IDLE;
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            count_q  <= '0;
        end else begin
            if (bus_if.we) mem_q[bus_if.waddr] <= bus_if.wdata;
            rvalid_q <= bus_if.re;
            if (bus_if.re) rdata_q <= host_val_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus_if.start) begin
                    state_q <= SCAN;
                    busy_q  <= 1'b1;
                    ptr_q   <= '0;
                    mask_q  <= '0;
                    count_q <= '0;
                end
                SCAN: if (!bus_if.re) begin
                    mask_q[ptr_q] <= flag_d;
                    count_q       <= count_q + {5'b0, flag_d};
                    ptr_q         <= ptr_q + 5'd1;
                    if (ptr_q == 5'd31) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.rdata  = rdata_q;
    assign bus_if.rvalid = rvalid_q;
    assign bus_if.busy   = busy_q;
    assign bus_if.done   = done_q;
    assign bus_if.mask   = mask_q;
    assign bus_if.count  = count_q;
endmodule

// File: tb/tb_grf_scan_arbiter.sv
// tb_grf_scan_arbiter: scoreboard bench for grf_scan_arbiter; host read data and scan results
// are queued when stimulus is driven and compared when rvalid/done appear.
module tb_grf_scan_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grf_scan_if bus ();
    grf_scan_arbiter dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    typedef struct {
        logic [31:0] m;
        logic [5:0]  c;
        int          lat;
    } scan_exp_t;

    logic [15:0] rd_q [$];
    scan_exp_t   sc_q [$];
    logic [15:0] model [32];
    int checks = 0;
    int errors = 0;

`ifdef GRF_SCAN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        model[a] = d;
        tick();
        bus.we = 1'b0;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = model[i] >= 16'h0020;
        return m;
    endfunction

    function automatic logic [5:0] model_count();
        logic [5:0] c = '0;
        for (int i = 0; i < 32; i++) c += {5'b0, model[i] >= 16'h0020};
        return c;
    endfunction

    task automatic run_to_done(input int k0, output int lat);
        int k = k0;
        lat = -1;
        while (k < 300) begin
            tick();
            k++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({bus.rdata, bus.rvalid, bus.busy, bus.done, bus.mask, bus.count} !== 56'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h rvalid=%b busy=%b done=%b mask=%h count=%0d, want all 0",
                     bus.rdata, bus.rvalid, bus.busy, bus.done, bus.mask, bus.count);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        scan_exp_t e;
        int lat;
        do_reset();
        wr(0, 16'h001F); wr(1, 16'h0020); wr(31, 16'hFFFF);
        sc_q.push_back('{model_mask(), model_count(), 32});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        run_to_done(0, lat);
        e = sc_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (bus.mask !== 32'h80000002 || bus.mask !== e.m) begin errors++; $display("FAIL basic_mask: got %h want %h", bus.mask, e.m); end
        checks++;
        if (bus.count !== e.c) begin errors++; $display("FAIL basic_count: got %0d want %0d", bus.count, e.c); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bus.busy); end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.mask !== e.m || bus.count !== e.c) begin
            errors++;
            $display("FAIL basic_hold: got done=%b mask=%h count=%0d want done=0 mask=%h count=%0d",
                     bus.done, bus.mask, bus.count, e.m, e.c);
        end
    endtask

    task automatic test_stall;
        scan_exp_t e;
        int lat;
        do_reset();
        wr(0, 16'h001F); wr(1, 16'h0020); wr(31, 16'hFFFF);
        sc_q.push_back('{32'h80000002, 6'd2, 35});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus.re = (k >= 10); bus.raddr = 5'd1;
            if (bus.re) rd_q.push_back(model[1]);
            tick();
            if (k >= 10) begin
                checks++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== rd_q.pop_front()) begin
                    errors++;
                    $display("FAIL stall_read_%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=0020", k, bus.rvalid, bus.rdata);
                end
            end
        end
        bus.re = 1'b0;
        run_to_done(12, lat);
        e = sc_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL stall_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (bus.mask !== e.m || bus.count !== e.c) begin
            errors++;
            $display("FAIL stall_result: got mask=%h count=%0d want mask=%h count=%0d", bus.mask, bus.count, e.m, e.c);
        end
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 16'h0020) begin
            errors++;
            $display("FAIL stall_rdata_hold: got rvalid=%b rdata=%h want rvalid=0 rdata=0020", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_double_start;
        scan_exp_t e;
        int lat;
        int extra = 0;
        do_reset();
        for (int i = 0; i < 32; i++) wr(i[4:0], 16'hFFFF);
        sc_q.push_back('{model_mask(), model_count(), 32});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.start = (k == 5);
            tick();
            bus.start = 1'b0;
        end
        run_to_done(5, lat);
        e = sc_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL dstart_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (bus.mask !== 32'hFFFFFFFF || bus.count !== 6'd32 || bus.mask !== e.m || bus.count !== e.c) begin
            errors++;
            $display("FAIL dstart_result: got mask=%h count=%0d want mask=%h count=%0d", bus.mask, bus.count, e.m, e.c);
        end
        repeat (40) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL dstart_no_second_scan: got %0d busy/done cycles want 0", extra); end
    endtask

    task automatic test_midscan_write;
        scan_exp_t e;
        int lat;
        do_reset();
        wr(0, 16'hFFFF);
        sc_q.push_back('{32'h00100001, 6'd2, 32});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.we = (k == 3 || k == 5);
            bus.waddr = (k == 3) ? 5'd0 : 5'd20;
            bus.wdata = (k == 3) ? 16'h0000 : 16'h0040;
            tick();
            bus.we = 1'b0;
        end
        run_to_done(5, lat);
        e = sc_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL midwr_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (bus.mask !== e.m || bus.count !== e.c) begin
            errors++;
            $display("FAIL midwr_result: got mask=%h count=%0d want mask=%h count=%0d", bus.mask, bus.count, e.m, e.c);
        end
    endtask

    task automatic test_same_cycle;
        scan_exp_t e;
        int lat;
        do_reset();
        sc_q.push_back('{BYP ? 32'h00000080 : 32'h0, BYP ? 6'd1 : 6'd0, 32});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus.we = (k == 8); bus.waddr = 5'd7; bus.wdata = 16'h0040;
            tick();
            bus.we = 1'b0;
        end
        run_to_done(8, lat);
        e = sc_q.pop_front();
        checks++;
        if (bus.mask !== e.m || bus.count !== e.c || lat != e.lat) begin
            errors++;
            $display("FAIL same_cycle_scan: got mask=%h count=%0d lat=%0d want mask=%h count=%0d lat=%0d",
                     bus.mask, bus.count, lat, e.m, e.c, e.lat);
        end
        tick();
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 16'h0040;
        bus.re = 1'b1; bus.raddr = 5'd9;
        rd_q.push_back(BYP ? 16'h0040 : 16'h0000);
        tick();
        bus.we = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== rd_q.pop_front()) begin
            errors++;
            $display("FAIL same_cycle_host: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", bus.rvalid, bus.rdata, BYP ? 16'h0040 : 16'h0000);
        end
        rd_q.push_back(16'h0040);
        tick();
        bus.re = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== rd_q.pop_front()) begin
            errors++;
            $display("FAIL host_after_write: got rvalid=%b rdata=%h want rvalid=1 rdata=0040", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_reset_mid;
        scan_exp_t e;
        int lat;
        do_reset();
        wr(3, 16'hFFFF); wr(30, 16'hFFFF);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (9) tick();
        bus.re = 1'b1; bus.raddr = 5'd3;
        tick();
        bus.re = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.mask !== 32'h8 || bus.count !== 6'd1 || bus.rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL pre_reset_state: got busy=%b mask=%h count=%0d rdata=%h want busy=1 mask=00000008 count=1 rdata=ffff",
                     bus.busy, bus.mask, bus.count, bus.rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rdata, bus.rvalid, bus.busy, bus.done, bus.mask, bus.count} !== 56'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdata=%h rvalid=%b busy=%b done=%b mask=%h count=%0d want all 0",
                     bus.rdata, bus.rvalid, bus.busy, bus.done, bus.mask, bus.count);
        end
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        rst_n = 1'b1;
        sc_q.push_back('{model_mask(), model_count(), 32});
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        run_to_done(0, lat);
        e = sc_q.pop_front();
        checks++;
        if (bus.mask !== e.m || bus.count !== e.c || lat != e.lat) begin
            errors++;
            $display("FAIL post_reset_scan: got mask=%h count=%0d lat=%0d want mask=%h count=%0d lat=%0d",
                     bus.mask, bus.count, lat, e.m, e.c, e.lat);
        end
    endtask

    initial begin
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re = 1'b0; bus.raddr = '0; bus.start = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_double_start();
        test_midscan_write();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_scan_arbiter.md
# grf_scan_arbiter

Owns a 32 x 16 general register file and shares its single read port between an external host and an internal threshold scanner. On request, the scanner walks every entry and applies the unsigned threshold check "value >= 0x0020 sets the flag". It produces a per-entry flag mask and a population count. Host reads always win the read port; the scan stalls while the host is reading.

## Interface
- DEPTH, 32: number of entries; fixed power of two; address width is 5.
- WIDTH, 16: entry width in bits.
- THRESH, 16'h0020: unsigned threshold; flag = (entry >= THRESH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  host write enable; always accepted.
- waddr  in  5  host write address.
- wdata  in  16  host write data.
- re  in  1  host read request; has priority over the scanner.
- raddr  in  5  host read address.
- rdata  out  16  host read data, registered.
- rvalid  out  1  one-cycle pulse; rdata is valid.
- start  in  1  scan request; sampled only in IDLE.
- busy  out  1  high while in state SCAN.
- done  out  1  one-cycle pulse on scan completion.
- mask  out  32  bit i = flag of entry i from the latest scan.
- count  out  6  number of set bits in mask, 0..32.

## Operation
- Reset (async, rst_n=0):
  - all entries = 0, state = IDLE, scan pointer = 0.
  - rdata = 0, rvalid = 0, busy = 0, done = 0, mask = 0, count = 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 moves to SCAN; pointer = 0, mask = 0, count = 0.
  - SCAN, cycle with re=0 (granted): read entry[pointer], set mask[pointer] = flag, count += flag, pointer += 1.
  - SCAN, pointer = 31 and granted: go to DONE.
  - SCAN, cycle with re=1: the scanner stalls; pointer, mask and count hold.
  - DONE: done=1 for this single cycle, then unconditionally return to IDLE.
- start while in SCAN or DONE is ignored; it is not queued.
- Host reads are served in every state: rdata <= entry[raddr], rvalid <= 1. rdata holds its value between reads.
- Host writes are accepted in every state, including mid-scan.
  - The mask reflects each entry's value at the moment it was scanned.
  - A later write to an already-scanned address does not change mask.
- Same-cycle write and read to the same address (host or scanner): the read returns the OLD value, unless the configuration macro below is defined.
- Flag compare is unsigned over the full 16 bits. Pointer wrap is never reached because the FSM leaves SCAN at 31.
- mask and count hold their final values after DONE until the next accepted start clears them.
- rst_n asserted mid-scan aborts the scan. All outputs return to their reset values and the register file is cleared.

## Timing
- Host read latency is 1 cycle: re at edge N gives rdata/rvalid valid after edge N.
- Scan with no host reads:
  - start sampled at edge E0.
  - busy = 1 after E0.
  - Entries 0..31 are scanned at edges E1..E32.
  - DONE is entered after E32: done=1 and busy=0 for that cycle.
  - IDLE is entered after E33.
- Each cycle of the SCAN state with re=1 delays completion by exactly one cycle.
- mask and count update incrementally at each granted scanning edge. They are final when done=1.
- Earliest back-to-back start is in the IDLE cycle after DONE.

## Configuration
- GRF_SCAN_BYPASS_EN defined:
  - A read (host or scanner) whose address equals waddr while we=1 in the same cycle returns wdata.
  - For the scanner, flag is computed on wdata.
- GRF_SCAN_BYPASS_EN undefined: such reads return the pre-write entry value.

## Test plan
- Reset: assert rst_n=0 mid-operation -> rdata=0, rvalid=0, busy=0, done=0, mask=0, count=0; a subsequent scan gives mask=0, count=0.
- Write entry0=16'h001F, entry1=16'h0020, entry31=16'hFFFF, all others 0; pulse start -> done after E32 with mask=32'h80000002, count=2; busy low during the done cycle.
- Same setup, hold re=1 for 3 cycles mid-scan reading address 1 -> rdata=16'h0020 with rvalid after each request; done is delayed to after E35; mask and count are unchanged.
- Write all entries to 16'hFFFF, start, then pulse start again at E5 -> second start ignored; single done; mask=32'hFFFFFFFF, count=32.
- During scan, write 16'h0000 to entry 0 after it is scanned (flag 1) -> mask[0]=1. Write 16'h0040 to entry 20 before it is scanned -> mask[20]=1.
- Same-cycle write of 16'h0040 to the scanner's current address, whose old value is 0:
  - GRF_SCAN_BYPASS_EN defined -> flag 1.
  - undefined -> flag 0.
  - Repeat with host read -> rdata = 16'h0040 with the macro defined, 16'h0000 without.
